// File: rtl/mf_disp_pkg.sv
// mf_disp_pkg -- shared definitions for the display fill engine.
//   FB_BASE_DEF / STRIDE_DEF / ROWS_DEF : framebuffer geometry defaults
//   CMD_BASE / CMD_FRAME_SWITCH_OFS     : display command block, frame-switch register
//   fill_state_t                        : fill engine FSM states
package mf_disp_pkg;

    localparam logic [15:0] FB_BASE_DEF          = 16'h0000;
    localparam int          STRIDE_DEF           = 80;
    localparam int          ROWS_DEF             = 240;
    localparam logic [15:0] CMD_BASE             = 16'hF000;
    localparam logic [15:0] CMD_FRAME_SWITCH_OFS = 16'h0010;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_FILL,
        ST_CMD,
        ST_DONE
    } fill_state_t;

endpackage

// File: rtl/mf_disp_fill_addr_gen.sv
// mf_disp_fill_addr_gen -- row-major address walker for a rectangle fill.
// Ports:
//   sys_clk, reset     : clock, synchronous active-high reset
//   load               : capture x/y/w/h and position at the top-left word
//   adv                : step to the next word (one accepted write)
//   x, y, w, h         : rectangle in word columns / rows (already range-checked)
//   addr               : current framebuffer word address
//   last_word          : current word is the bottom-right corner
module mf_disp_fill_addr_gen
    import mf_disp_pkg::*;
#(
    parameter logic [15:0] FB_BASE = FB_BASE_DEF,
    parameter int          STRIDE  = STRIDE_DEF
) (
    input  logic        sys_clk,
    input  logic        reset,
    input  logic        load,
    input  logic        adv,
    input  logic [6:0]  x,
    input  logic [7:0]  y,
    input  logic [6:0]  w,
    input  logic [7:0]  h,
    output logic [15:0] addr,
    output logic        last_word
);

    logic [6:0]  col;
    logic [7:0]  row;
    logic [15:0] row_base;
    logic [6:0]  x_q;
    logic [6:0]  last_col;
    logic [7:0]  last_row;

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            col      <= '0;
            row      <= '0;
            row_base <= '0;
            x_q      <= '0;
            last_col <= '0;
            last_row <= '0;
        end else if (load) begin
            col      <= x;
            row      <= y;
            // Only multiply at load; the walk itself advances by adding STRIDE.
            row_base <= FB_BASE + 16'(y) * 16'(STRIDE);
            x_q      <= x;
            last_col <= x + w - 7'd1;
            last_row <= y + h - 8'd1;
        end else if (adv) begin
            if (col == last_col) begin
                col      <= x_q;
                row      <= row + 8'd1;
                row_base <= row_base + 16'(STRIDE);
            end else begin
                col <= col + 7'd1;
            end
        end
    end

    assign addr      = row_base + {9'b0, col};
    assign last_word = (col == last_col) && (row == last_row);

endmodule

// File: rtl/mf_disp_fill_eng.sv
// mf_disp_fill_eng -- fills a rectangle of the framebuffer with one 32-bit word.
// Ports:
//   sys_clk, reset            : clock, synchronous active-high reset
//   fill_start                : one-cycle request, operands sampled with it (IDLE only)
//   fill_x/y/w/h, fill_data   : rectangle (word columns / rows) and fill word
//   fill_busy/done/err        : status; done and err are one-cycle pulses
//   sys_wr_vld/rdy/addr/data  : valid/ready write port into the display memory map
// Build option: MF_DISP_FILL_CMD_EN adds a frame-switch command write after the fill.
//
// state    | meaning
// IDLE     | waiting for fill_start
// CHECK    | empty / bounds check of latched operands
// FILL     | streaming fill words, one per accepted handshake
// CMD      | frame-switch write (MF_DISP_FILL_CMD_EN builds only)
// DONE     | fill_done pulse, back to IDLE
module mf_disp_fill_eng
    import mf_disp_pkg::*;
#(
    parameter logic [15:0] FB_BASE = FB_BASE_DEF,
    parameter int          STRIDE  = STRIDE_DEF,
    parameter int          ROWS    = ROWS_DEF
) (
    input  logic        sys_clk,
    input  logic        reset,
    input  logic        fill_start,
    input  logic [6:0]  fill_x,
    input  logic [7:0]  fill_y,
    input  logic [6:0]  fill_w,
    input  logic [7:0]  fill_h,
    input  logic [31:0] fill_data,
    output logic        fill_busy,
    output logic        fill_done,
    output logic        fill_err,
    output logic        sys_wr_vld,
    input  logic        sys_wr_rdy,
    output logic [15:0] sys_wr_addr,
    output logic [31:0] sys_wr_data
);

    fill_state_t state_q, state_d;

    logic [6:0]  op_x, op_w;
    logic [7:0]  op_y, op_h;
    logic [31:0] op_data;
    logic        err_q, err_set;
    logic        load, adv;
    logic [15:0] fb_addr;
    logic        last_word;
    logic [8:0]  sum_x, sum_y;
    logic        out_of_bounds;

    // Widened sums so a huge x+w or y+h cannot wrap back into range.
    assign sum_x         = {2'b0, op_x} + {2'b0, op_w};
    assign sum_y         = {1'b0, op_y} + {1'b0, op_h};
    assign out_of_bounds = (sum_x > 9'(STRIDE)) || (sum_y > 9'(ROWS));

    mf_disp_fill_addr_gen #(
        .FB_BASE (FB_BASE),
        .STRIDE  (STRIDE)
    ) u_addr_gen (
        .sys_clk   (sys_clk),
        .reset     (reset),
        .load      (load),
        .adv       (adv),
        .x         (op_x),
        .y         (op_y),
        .w         (op_w),
        .h         (op_h),
        .addr      (fb_addr),
        .last_word (last_word)
    );

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            err_q   <= 1'b0;
            op_x    <= '0;
            op_y    <= '0;
            op_w    <= '0;
            op_h    <= '0;
            op_data <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_set;
            if (state_q == ST_IDLE && fill_start) begin
                op_x    <= fill_x;
                op_y    <= fill_y;
                op_w    <= fill_w;
                op_h    <= fill_h;
                op_data <= fill_data;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        load        = 1'b0;
        adv         = 1'b0;
        err_set     = 1'b0;
        fill_busy   = 1'b0;
        fill_done   = 1'b0;
        sys_wr_vld  = 1'b0;
        sys_wr_addr = '0;
        sys_wr_data = '0;
        case (state_q)
            ST_IDLE: begin
                if (fill_start) state_d = ST_CHECK;
            end
            ST_CHECK: begin
                fill_busy = 1'b1;
                if (op_w == 7'd0 || op_h == 8'd0) begin
                    state_d = ST_DONE;
                end else if (out_of_bounds) begin
                    err_set = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    load    = 1'b1;
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                fill_busy   = 1'b1;
                sys_wr_vld  = 1'b1;
                sys_wr_addr = fb_addr;
                sys_wr_data = op_data;
                if (sys_wr_rdy) begin
                    adv = 1'b1;
                    if (last_word) begin
`ifdef MF_DISP_FILL_CMD_EN
                        state_d = ST_CMD;
`else
                        state_d = ST_DONE;
`endif
                    end
                end
            end
`ifdef MF_DISP_FILL_CMD_EN
            ST_CMD: begin
                fill_busy   = 1'b1;
                sys_wr_vld  = 1'b1;
                sys_wr_addr = CMD_BASE + CMD_FRAME_SWITCH_OFS;
                sys_wr_data = 32'h1;
                if (sys_wr_rdy) state_d = ST_DONE;
            end
`endif
            ST_DONE: begin
                fill_done = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign fill_err = err_q;

endmodule
